// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep controller.
//   - ST_IDLE/ST_DRIVE/ST_DONE: state encodings, also used as the values of state_e
//   - DefaultDwell: default number of clocks each vector is held
//   - n_vec(): number of vectors (and truth-table width) for a given input count
package tt_pkg;

  localparam int unsigned DefaultDwell = 20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StDrive = ST_DRIVE,
    StDone  = ST_DONE
  } state_e;

  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_dwell_timer.sv
// Dwell timer for the sweep controller: counts the clocks a vector has been held.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset (count -> 0)
//   clear_i  force count to 0 (has priority over en_i)
//   en_i     advance the count; wraps to 0 after Dwell-1
//   last_o   high while count == Dwell-1
module tt_dwell_timer
  import tt_pkg::*;
#(
  parameter int unsigned Dwell = DefaultDwell
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o
);

  // A one-bit counter keeps Dwell == 1 legal; it simply never leaves 0.
  localparam int unsigned CntW = (Dwell > 1) ? $clog2(Dwell) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Dwell - 1);

  if (Dwell == 0) begin : g_bad_dwell
    $error("tt_dwell_timer: Dwell must be >= 1");
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller. On start it drives every input vector {a,b,c,d} = 0..NVec-1
// in order, holds each for Dwell clocks, samples f on the last clock of each hold into tt,
// then pulses done for one cycle.
// Optional feature macro: TT_CHECK_EN (adds golden-table compare: expected_i, mismatch_o,
// err_cnt_o).
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-high reset; aborts a sweep without a done pulse
//   start_i     sweep request, only honoured in idle
//   a_o..d_o    registered DUT inputs, a_o = vector MSB, d_o = LSB
//   f_i         DUT output, combinational from a_o..d_o
//   busy_o      high while vectors are being driven
//   done_o      one-cycle completion pulse
//   tt_o        tt_o[i] = f_i sampled while vector i was driven
//   expected_i  golden truth table                     (TT_CHECK_EN)
//   mismatch_o  sticky: some sampled bit differed      (TT_CHECK_EN)
//   err_cnt_o   number of differing vectors, saturates (TT_CHECK_EN)
module tt_sweep_ctrl
  import tt_pkg::*;
#(
  parameter int unsigned NIn   = 4,
  parameter int unsigned Dwell = DefaultDwell,
  localparam int unsigned NVec = n_vec(NIn)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            a_o,
  output logic            b_o,
  output logic            c_o,
  output logic            d_o,
  input  logic            f_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [NVec-1:0] tt_o
`ifdef TT_CHECK_EN
  ,
  input  logic [NVec-1:0] expected_i,
  output logic            mismatch_o,
  output logic [NIn:0]    err_cnt_o
`endif
);

  localparam logic [NIn-1:0] VecLast = NIn'(NVec - 1);

  // The DUT interface has exactly four drive pins.
  if (NIn != 4) begin : g_bad_nin
    $error("tt_sweep_ctrl: NIn must be 4 to map onto a..d");
  end

  state_e          state_q, state_d;
  logic [NIn-1:0]  vec_q, vec_d;
  logic [NVec-1:0] tt_q, tt_d;
  logic            dwell_last;
  logic            accept;
  logic            sample;

  assign accept = (state_q == StIdle) && start_i;
  assign sample = (state_q == StDrive) && dwell_last;

  // Held at zero outside DRIVE so every vector gets a full Dwell.
  tt_dwell_timer #(
    .Dwell(Dwell)
  ) u_dwell_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(state_q != StDrive),
    .en_i   (state_q == StDrive),
    .last_o (dwell_last)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    tt_d    = tt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          vec_d   = '0;
          tt_d    = '0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (dwell_last) begin
          tt_d[vec_q] = f_i;
          if (vec_q == VecLast) begin
            state_d = StDone;
          end else begin
            vec_d = vec_q + NIn'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      vec_q   <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tt_q    <= tt_d;
    end
  end

  assign busy_o = (state_q == StDrive);
  assign done_o = (state_q == StDone);
  assign tt_o   = tt_q;
  assign a_o    = vec_q[NIn-1];
  assign b_o    = vec_q[NIn-2];
  assign c_o    = vec_q[NIn-3];
  assign d_o    = vec_q[0];

`ifdef TT_CHECK_EN
  localparam int unsigned ErrW = NIn + 1;
  localparam logic [NIn:0] ErrMax = ErrW'(NVec);

  logic           mismatch_q, mismatch_d;
  logic [NIn:0]   err_q, err_d;

  always_comb begin
    mismatch_d = mismatch_q;
    err_d      = err_q;
    if (accept) begin
      mismatch_d = 1'b0;
      err_d      = '0;
    end else if (sample && (f_i != expected_i[vec_q])) begin
      mismatch_d = 1'b1;
      if (err_q != ErrMax) begin
        err_d = err_q + ErrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign mismatch_o = mismatch_q;
  assign err_cnt_o  = err_q;
`else
  logic unused_accept;
  assign unused_accept = accept ^ sample;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: three instances (Dwell 20, 1, 2) driving a stub DUT each.
// Stimulus pushes expected results into a queue; a monitor pops on every done pulse.
module tb_tt_sweep_ctrl;

  localparam int unsigned NVec = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  start_r = '0;
  logic [2:0]  a_w, b_w, c_w, d_w, f_w, busy_w, done_w;
  logic [15:0] tt_w   [3];
  logic [1:0]  mode   [3];
  logic [15:0] golden [3];
`ifdef TT_CHECK_EN
  logic [2:0]  mis_w;
  logic [4:0]  err_w  [3];
`endif

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub DUTs: 0 = parity, 1 = 4-input AND, 2 = mux (a ? b : c)
  function automatic logic fstub(input logic [1:0] m, input logic [3:0] v);
    case (m)
      2'd0:    return ^v;
      2'd1:    return &v;
      2'd2:    return v[3] ? v[2] : v[1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int dwell_of(input int i);
    return (i == 0) ? 20 : (i == 1) ? 1 : 2;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tt_sweep_ctrl #(
      .NIn  (4),
      .Dwell(dwell_of(g))
    ) u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start_r[g]),
      .a_o       (a_w[g]),
      .b_o       (b_w[g]),
      .c_o       (c_w[g]),
      .d_o       (d_w[g]),
      .f_i       (f_w[g]),
      .busy_o    (busy_w[g]),
      .done_o    (done_w[g]),
      .tt_o      (tt_w[g])
`ifdef TT_CHECK_EN
      ,
      .expected_i(golden[g]),
      .mismatch_o(mis_w[g]),
      .err_cnt_o (err_w[g])
`endif
    );
    assign f_w[g] = fstub(mode[g], {a_w[g], b_w[g], c_w[g], d_w[g]});
  end

  typedef struct {
    int          inst;
    logic [15:0] tt;
    int          acc;      // cyc value during the first cycle after accept
    int          elapsed;  // cycles from accept to done, done cycle included
    int          busy;
    logic        mis;
    logic [4:0]  err;
  } exp_t;

  exp_t q[$];
  int   bcnt [3] = '{0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          bcnt[i] = 0;
        end else begin
          if (busy_w[i]) bcnt[i]++;
          if (done_w[i]) begin
            if (q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_done: inst %0d got done=1, required done=0 (cyc %0d)", i,
                       cyc);
            end else begin
              e = q.pop_front();
              check("done_inst", 32'(i), 32'(e.inst));
              check("tt", 32'(tt_w[i]), 32'(e.tt));
              check("done_latency", 32'(cyc - e.acc + 1), 32'(e.elapsed));
              check("busy_cycles", 32'(bcnt[i]), 32'(e.busy));
`ifdef TT_CHECK_EN
              check("mismatch", 32'(mis_w[i]), 32'(e.mis));
              check("err_cnt", 32'(err_w[i]), 32'(e.err));
`endif
            end
            bcnt[i] = 0;
          end
        end
      end
    end
  end

  task automatic start_sweep(input int i, output int acc);
    @(negedge clk);
    start_r[i] = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    start_r[i] = 1'b0;
  endtask

  task automatic push_exp(input int i, input logic [15:0] tt, input int acc);
    exp_t e;
    int   ones;
    ones      = $countones(tt ^ golden[i]);
    e.inst    = i;
    e.tt      = tt;
    e.acc     = acc;
    e.busy    = int'(NVec) * dwell_of(i);
    e.elapsed = e.busy + 1;
    e.mis     = (tt != golden[i]);
    e.err     = 5'((ones > int'(NVec)) ? int'(NVec) : ones);
    q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && q.size() != 0; n++) @(negedge clk);
    check("done_seen_in_budget", 32'(q.size()), 32'd0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_vec(input int i, input logic [3:0] v, input int budget);
    for (int n = 0; n < budget && {a_w[i], b_w[i], c_w[i], d_w[i]} != v; n++) @(negedge clk);
    check("reach_vec", 32'({a_w[i], b_w[i], c_w[i], d_w[i]}), 32'(v));
  endtask

  task automatic check_zero(input int i);
    check("rst_vec", 32'({a_w[i], b_w[i], c_w[i], d_w[i]}), 32'd0);
    check("rst_busy", 32'(busy_w[i]), 32'd0);
    check("rst_done", 32'(done_w[i]), 32'd0);
    check("rst_tt", 32'(tt_w[i]), 32'd0);
`ifdef TT_CHECK_EN
    check("rst_mismatch", 32'(mis_w[i]), 32'd0);
    check("rst_err_cnt", 32'(err_w[i]), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, acc2;
    for (int i = 0; i < 3; i++) begin
      mode[i]   = 2'd0;
      golden[i] = 16'h6996;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    check_zero(2);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Parity, Dwell 20: done 321 cycles after accept, busy 320
    start_sweep(0, acc);
    push_exp(0, 16'h6996, acc);
    wait_idle(400);
    check("last_vec_held", 32'({a_w[0], b_w[0], c_w[0], d_w[0]}), 32'hf);
    check("busy_low_after", 32'(busy_w[0]), 32'd0);
    check("tt_stable_after", 32'(tt_w[0]), 32'h6996);

    // AND4, Dwell 1: done 17 cycles after accept
    mode[1] = 2'd1;
    golden[1] = 16'h8000;
    start_sweep(1, acc);
    push_exp(1, 16'h8000, acc);
    wait_idle(60);

    // Mux a ? b : c, Dwell 1
    mode[1] = 2'd2;
    golden[1] = 16'hf0cc;
    start_sweep(1, acc);
    push_exp(1, 16'hf0cc, acc);
    wait_idle(60);

    // Golden off by one bit: one mismatching vector when the check is built in
    golden[0] = 16'h6997;
    start_sweep(0, acc);
    push_exp(0, 16'h6996, acc);
    wait_idle(400);
    golden[0] = 16'h6996;

    // Reset at vec 7 aborts with no done; next sweep is complete
    start_sweep(0, acc);
    wait_vec(0, 4'd7, 400);
    #2 rst = 1'b1;
    #1 check_zero(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_restart_after_rst", 32'(busy_w[0]), 32'd0);
    start_sweep(0, acc);
    push_exp(0, 16'h6996, acc);
    wait_idle(400);

    // Start pulse mid-sweep is ignored: one done, no second sweep
    start_sweep(0, acc);
    push_exp(0, 16'h6996, acc);
    wait_vec(0, 4'd3, 200);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_idle(400);
    repeat (30) @(negedge clk);
    check("no_queued_sweep", 32'(busy_w[0]), 32'd0);

    // Start held high, Dwell 2: second accept 34 cycles after the first
    @(negedge clk);
    start_r[2] = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    push_exp(2, 16'h6996, acc);
    acc2 = acc + 34;
    push_exp(2, 16'h6996, acc2);
    for (int n = 0; n < 60 && cyc != acc2; n++) @(negedge clk);
    check("second_accept_busy", 32'(busy_w[2]), 32'd1);
    check("tt_cleared_on_accept", 32'(tt_w[2]), 32'd0);
    start_r[2] = 1'b0;
    wait_idle(100);
    check("idle_after_hold", 32'(busy_w[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
